// File: rtl/framebuffer_reader.sv
// Streams one frame of RGB565 words from RAM as 24-bit pixels through a credit-limited skid FIFO.
// Optional macro PIXEL_EXPAND_EN selects bit-replicated colour expansion instead of zero padding.
module framebuffer_reader #(
    parameter int unsigned RAM_ADDR_WIDTH = 32,
    parameter int unsigned RAM_DATA_WIDTH = 16,
    parameter int unsigned IMAGE_SIZE     = 80*48,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      bufferSel,
    output logic                      busy,
    output logic [RAM_ADDR_WIDTH-1:0] ramAddr,
    output logic                      ramReadEnable,
    input  logic [RAM_DATA_WIDTH-1:0] ramData,
    output logic [23:0]               pixel,
    output logic                      pixelValid,
    input  logic                      pixelReady,
    output logic                      frameDone
);

    localparam int unsigned FIFO_DEPTH = READ_LATENCY + 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W      = $clog2(IMAGE_SIZE + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                state_q, state_d;
    logic                      buf_sel_q, buf_sel_d;
    logic [IDX_W-1:0]          read_idx_q, read_idx_d;
    logic [IDX_W-1:0]          out_idx_q, out_idx_d;
    logic                      busy_q, busy_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      rd_en_q, rd_en_d;
    logic                      done_q, done_d;
    logic [READ_LATENCY-1:0]   pipe_q, pipe_d;

    logic [RAM_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          fifo_count_q, fifo_count_d;
    logic                      valid_q, valid_d;
    logic [23:0]               pixel_q, pixel_d;

    logic                      push, pop, issue, credit_ok;
    logic [CNT_W-1:0]          in_flight;
    logic [RAM_ADDR_WIDTH-1:0] base;

    function automatic logic [23:0] expand(input logic [15:0] w);
`ifdef PIXEL_EXPAND_EN
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
`else
        return {w[15:11], 3'b000, w[10:5], 2'b00, w[4:0], 3'b000};
`endif
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = pipe_q[READ_LATENCY-1];
    assign pop  = valid_q & pixelReady;
    assign base = buf_sel_q ? RAM_ADDR_WIDTH'(IMAGE_SIZE) : '0;

    // A pop this cycle frees a slot, so it counts toward the credit for the next read.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            in_flight = in_flight + CNT_W'(pipe_q[i]);
        end
        credit_ok = (32'(fifo_count_q) - 32'(pop) + 32'(in_flight)) < FIFO_DEPTH;
    end

    always_comb begin
        state_d    = state_q;
        buf_sel_d  = buf_sel_q;
        read_idx_d = read_idx_q;
        out_idx_d  = out_idx_q;
        busy_d     = busy_q;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;
        if (pop) begin
            out_idx_d = out_idx_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    buf_sel_d  = bufferSel;
                    read_idx_d = '0;
                    out_idx_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    rd_en_d    = 1'b1;
                    addr_d     = base + RAM_ADDR_WIDTH'(read_idx_q);
                    read_idx_d = read_idx_q + 1'b1;
                    if (read_idx_q == IDX_W'(IMAGE_SIZE - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_idx_q == IDX_W'(IMAGE_SIZE - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pipe_d = (pipe_q << 1) | READ_LATENCY'(issue);
    end

    // Output register tracks the post-update FIFO head, bypassing the array when it is empty.
    always_comb begin
        fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        valid_d      = (fifo_count_d != '0);
        pixel_d      = pixel_q;
        if (push && fifo_count_q == CNT_W'(pop)) begin
            pixel_d = expand(ramData[15:0]);
        end else if (valid_d) begin
            pixel_d = expand(mem_q[rd_ptr_d][15:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            buf_sel_q    <= 1'b0;
            read_idx_q   <= '0;
            out_idx_q    <= '0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            rd_en_q      <= 1'b0;
            done_q       <= 1'b0;
            pipe_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_count_q <= '0;
            valid_q      <= 1'b0;
            pixel_q      <= '0;
        end else begin
            state_q      <= state_d;
            buf_sel_q    <= buf_sel_d;
            read_idx_q   <= read_idx_d;
            out_idx_q    <= out_idx_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            done_q       <= done_d;
            pipe_q       <= pipe_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_count_q <= fifo_count_d;
            valid_q      <= valid_d;
            pixel_q      <= pixel_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= ramData;
        end
    end

    assign busy          = busy_q;
    assign ramAddr       = addr_q;
    assign ramReadEnable = rd_en_q;
    assign pixel         = pixel_q;
    assign pixelValid    = valid_q;
    assign frameDone     = done_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Scoreboard bench for framebuffer_reader: synchronous RAM model (latency 2), expected
// addresses and pixels queued at each accepted start and retired as the DUT produces them.
module tb_framebuffer_reader;

    localparam int unsigned IMG = 3840;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bufferSel;
    logic        busy;
    logic [31:0] ramAddr;
    logic        ramReadEnable;
    logic [15:0] ramData;
    logic [23:0] pixel;
    logic        pixelValid;
    logic        pixelReady;
    logic        frameDone;

    int vectors     = 0;
    int miscompares = 0;
    int data_mode   = 0;
    bit rand_ready  = 1'b0;
    int hs_cnt      = 0;
    int done_cnt    = 0;

    logic [31:0] exp_addr [$];
    logic [23:0] exp_pix  [$];
    logic [15:0] ram_q = '0;

    framebuffer_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bufferSel    (bufferSel),
        .busy         (busy),
        .ramAddr      (ramAddr),
        .ramReadEnable(ramReadEnable),
        .ramData      (ramData),
        .pixel        (pixel),
        .pixelValid   (pixelValid),
        .pixelReady   (pixelReady),
        .frameDone    (frameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_word(input logic [31:0] a);
        if (data_mode == 0) return a[15:0];
        case (a % 3)
            0:       return 16'hFFFF;
            1:       return 16'hF800;
            default: return 16'h07E0;
        endcase
    endfunction

    function automatic logic [23:0] exp_pixel(input logic [31:0] a);
        logic [15:0] w;
        logic [7:0]  r5, g6, b5, r8, g8, b8;
        if (data_mode != 0) begin
`ifdef PIXEL_EXPAND_EN
            case (a % 3)
                0:       return 24'hFFFFFF;
                1:       return 24'hFF0000;
                default: return 24'h00FF00;
            endcase
`else
            case (a % 3)
                0:       return 24'hF8FCF8;
                1:       return 24'hF80000;
                default: return 24'h00FC00;
            endcase
`endif
        end
        w  = a[15:0];
        r5 = 8'(w >> 11);
        g6 = 8'((w >> 5) & 16'h3F);
        b5 = 8'(w & 16'h1F);
`ifdef PIXEL_EXPAND_EN
        r8 = 8'((r5 << 3) | (r5 >> 2));
        g8 = 8'((g6 << 2) | (g6 >> 4));
        b8 = 8'((b5 << 3) | (b5 >> 2));
`else
        r8 = 8'(r5 << 3);
        g8 = 8'(g6 << 2);
        b8 = 8'(b5 << 3);
`endif
        return {r8, g8, b8};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous RAM: strobe sampled on one edge, data captured by the DUT on the next.
    always @(posedge clk) begin
        if (ramReadEnable) ram_q <= ram_word(ramAddr);
    end
    assign ramData = ram_q;

    initial begin
        pixelReady = 1'b1;
        forever begin
            @(posedge clk);
            #1 pixelReady = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [23:0] prev_p = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(pixelValid), 32'd1);
                chk("hold_pixel", 32'(pixel), 32'(prev_p));
            end
            if (pixelValid && pixelReady) begin
                hs_cnt++;
                if (exp_pix.size() == 0) chk("pix_extra", 32'd1, 32'd0);
                else chk("pixel", 32'(pixel), 32'(exp_pix.pop_front()));
            end
            if (ramReadEnable) begin
                if (exp_addr.size() == 0) chk("addr_extra", 32'd1, 32'd0);
                else chk("ram_addr", ramAddr, exp_addr.pop_front());
            end
            if (frameDone) begin
                done_cnt++;
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_pix_left", 32'(exp_pix.size()), 32'd0);
                chk("done_addr_left", 32'(exp_addr.size()), 32'd0);
            end
            prev_v = pixelValid;
            prev_r = pixelReady;
            prev_p = pixel;
        end
    end

    task automatic launch(input logic sel, input bit accept);
        logic [31:0] a;
        #1;
        start     = 1'b1;
        bufferSel = sel;
        if (accept) begin
            for (int i = 0; i < int'(IMG); i++) begin
                a = sel ? 32'(IMG + i) : 32'(i);
                exp_addr.push_back(a);
                exp_pix.push_back(exp_pixel(a));
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic first_latency(input string tag);
        int n = 1;
        while (!pixelValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n), 32'd4);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frameDone && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(frameDone), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_addr"},  ramAddr, 32'd0);
        chk({tag, "_rden"},  32'(ramReadEnable), 32'd0);
        chk({tag, "_valid"}, 32'(pixelValid), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_done"},  32'(frameDone), 32'd0);
    endtask

    initial begin
        int d0, h0, n;
        rst = 1'b1;
        start = 1'b0;
        bufferSel = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1: continuous stream from buffer 0
        d0 = done_cnt;
        launch(1'b0, 1'b1);
        first_latency("t1_first_valid");
        n = 0;
        while (!frameDone && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("t1_stream_cycles", 32'(n), 32'(IMG));
        @(negedge clk);
        chk("t1_done_pulse", 32'(frameDone), 32'd0);
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);

        // T2: buffer 1, bufferSel toggled mid-frame
        launch(1'b1, 1'b1);
        repeat (100) @(negedge clk);
        bufferSel = 1'b0;
        wait_done("t2_done");
        @(negedge clk);

        // T3: random backpressure
        rand_ready = 1'b1;
        launch(1'b0, 1'b1);
        wait_done("t3_done");
        rand_ready = 1'b0;
        @(negedge clk);

        // T4: colour expansion constants
        data_mode = 1;
        launch(1'b0, 1'b1);
        wait_done("t4_done");
        @(negedge clk);
        data_mode = 0;

        // T5: start ignored while busy, then accepted in the frameDone cycle
        d0 = done_cnt;
        launch(1'b0, 1'b1);
        repeat (500) @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd1);
        launch(1'b1, 1'b0);
        wait_done("t5_done_a");
        chk("t5_idle_on_done", 32'(busy), 32'd0);
        launch(1'b1, 1'b1);
        first_latency("t5_b2b_first_valid");
        wait_done("t5_done_b");
        @(negedge clk);
        chk("t5_done_count", 32'(done_cnt - d0), 32'd2);

        // T6: reset mid-frame, then a clean frame
        d0 = done_cnt;
        launch(1'b0, 1'b1);
        h0 = hs_cnt;
        n = 0;
        while ((hs_cnt - h0) < 1000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_1000", 32'((hs_cnt - h0) >= 1000), 32'd1);
        #2 rst = 1'b1;
        #1 check_idle_outputs("t6_async");
        exp_addr.delete();
        exp_pix.delete();
        repeat (3) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        launch(1'b0, 1'b1);
        first_latency("t6_first_valid");
        wait_done("t6_done");
        @(negedge clk);
        chk("t6_done_count", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
